// File: rtl/l2_feeder.sv
// rtl/l2_feeder.sv - ping-pong pixel-vector buffer streaming channel pairs to layer_2
module l2_feeder #(
    parameter int N_CH = 20,
    parameter int PIX  = 121,
    parameter int DW   = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [4:0]           wr_ch,
    input  logic signed [DW-1:0] wr_data,
    input  logic                 wr_last,
    output logic                 wr_rdy,
    output logic                 strt,
    output logic signed [DW-1:0] din_0,
    output logic signed [DW-1:0] din_1,
    input  logic                 bsy_in,
    input  logic                 tx_done,
    output logic [6:0]           pix_cnt,
    output logic                 frm_done
);
    localparam int NP = N_CH / 2;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(NP - 1);

    typedef enum logic [1:0] {IDLE, STRT, SEND, WAIT} state_t;

    state_t               state;
    logic [PW-1:0]        p;
    logic                 fill_ptr;
    logic                 send_ptr;
    logic [1:0]           full_cnt;
    logic [1:0]           full_cnt_nxt;
    logic signed [DW-1:0] mem [2][N_CH];

    logic                 wr_acc;
    logic                 rel;
    logic [PW-1:0]        nxt_pair;
    logic signed [DW-1:0] rd_even;
    logic signed [DW-1:0] rd_odd;

    // Write acceptance, bank release, next occupancy and the pair to present next cycle
    always_comb begin
        wr_acc       = wr_en && wr_rdy && !tx_done;
        rel          = (state == WAIT) && !bsy_in && !tx_done;
        full_cnt_nxt = full_cnt;
        if (wr_acc && wr_last && !rel) begin
            full_cnt_nxt = full_cnt + 2'd1;
        end else if (rel && !(wr_acc && wr_last)) begin
            full_cnt_nxt = full_cnt - 2'd1;
        end
        nxt_pair = '0;
        if (state == SEND && p != P_LAST) begin
            nxt_pair = p + 1'b1;
        end
        rd_even = mem[send_ptr][{nxt_pair, 1'b0}];
        rd_odd  = mem[send_ptr][{nxt_pair, 1'b1}];
    end

    // Bank storage; only the fill bank is ever written, so the bank being sent stays stable
    always_ff @(posedge clk) begin
        if (wr_acc && (wr_ch < 5'(N_CH))) begin
            mem[fill_ptr][wr_ch] <= wr_data;
        end
    end

    // Bank bookkeeping: pointers, occupancy and the registered ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_ptr <= 1'b0;
            send_ptr <= 1'b0;
            full_cnt <= 2'd0;
            wr_rdy   <= 1'b1;
        end else if (tx_done) begin
            fill_ptr <= 1'b0;
            send_ptr <= 1'b0;
            full_cnt <= 2'd0;
            wr_rdy   <= 1'b1;
        end else begin
            if (wr_acc && wr_last) begin
                fill_ptr <= ~fill_ptr;
            end
            if (rel) begin
                send_ptr <= ~send_ptr;
            end
            full_cnt <= full_cnt_nxt;
            wr_rdy   <= (full_cnt_nxt != 2'd2);
        end
    end

    // Transmit FSM: start pulse, pair streaming, downstream wait and frame counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            p        <= '0;
            strt     <= 1'b0;
            din_0    <= '0;
            din_1    <= '0;
            pix_cnt  <= '0;
            frm_done <= 1'b0;
        end else if (tx_done) begin
            state    <= IDLE;
            p        <= '0;
            strt     <= 1'b0;
            din_0    <= '0;
            din_1    <= '0;
            pix_cnt  <= '0;
            frm_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    strt  <= 1'b0;
                    din_0 <= '0;
                    din_1 <= '0;
                    if (full_cnt != 2'd0 && !bsy_in && !frm_done) begin
                        state <= STRT;
                        strt  <= 1'b1;
                    end
                end
                STRT: begin
                    strt  <= 1'b0;
                    p     <= '0;
                    din_0 <= rd_even;
                    din_1 <= rd_odd;
                    state <= SEND;
                end
                SEND: begin
                    if (p == P_LAST) begin
                        din_0 <= '0;
                        din_1 <= '0;
                        state <= WAIT;
                    end else begin
                        p     <= nxt_pair;
                        din_0 <= rd_even;
                        din_1 <= rd_odd;
                    end
                end
                WAIT: begin
                    if (!bsy_in) begin
                        state <= IDLE;
                        if (pix_cnt != 7'(PIX)) begin
                            pix_cnt <= pix_cnt + 7'd1;
                        end
                        if (pix_cnt == 7'(PIX - 1)) begin
                            frm_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
